// File: rtl/rf_arbiter_if.sv
// rf_arbiter_if: requester ports and regfile control bundle for rf_arbiter.
interface rf_arbiter_if #(
    parameter int AW = 3,
    parameter int DW = 32,
    parameter int MW = 4
);
    logic          spi_req, spi_we, spi_gnt, spi_rvalid;
    logic [AW-1:0] spi_addr;
    logic [DW-1:0] spi_wdata, spi_rdata;
    logic [MW-1:0] spi_wmask;
    logic          core_req, core_we, core_gnt, core_rvalid;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic [MW-1:0] core_wmask;
    logic [AW-1:0] rf_addr;
    logic          rf_we, busy;
    logic [DW-1:0] rf_wdata, rf_rdata;
    logic [MW-1:0] rf_wmask;
    modport master (
        output spi_req, spi_we, spi_addr, spi_wdata, spi_wmask,
        output core_req, core_we, core_addr, core_wdata, core_wmask, rf_rdata,
        input  spi_gnt, spi_rvalid, spi_rdata, core_gnt, core_rvalid, core_rdata,
        input  rf_addr, rf_we, rf_wdata, rf_wmask, busy
    );
    modport slave (
        input  spi_req, spi_we, spi_addr, spi_wdata, spi_wmask,
        input  core_req, core_we, core_addr, core_wdata, core_wmask, rf_rdata,
        output spi_gnt, spi_rvalid, spi_rdata, core_gnt, core_rvalid, core_rdata,
        output rf_addr, rf_we, rf_wdata, rf_wmask, busy
    );
endinterface

// File: rtl/rf_arbiter.sv
// rf_arbiter: shares the single-port config regfile between SPI and core, SPI priority with core anti-starvation.
module rf_arbiter #(
    parameter int AW       = 3,
    parameter int DW       = 32,
    parameter int MW       = 4,
    parameter int MAX_WAIT = 4
) (
    input logic        clk,
    input logic        rst,
    rf_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RDATA = 2'd2;
    localparam logic [3:0] WMAX  = 4'(MAX_WAIT);

    logic [1:0]    state;
    logic [3:0]    wait_cnt;
    logic          owner;
    logic          idle, core_win, spi_win, grant, w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic [MW-1:0] w_wmask;

    // grants are combinational in IDLE; masked during reset so all outputs read 0
    assign idle     = state == IDLE && !rst;
    assign core_win = idle && bus.core_req && (wait_cnt == WMAX || !bus.spi_req);
    assign spi_win  = idle && bus.spi_req && !core_win;
    assign grant    = core_win || spi_win;
    assign w_we     = core_win ? bus.core_we    : bus.spi_we;
    assign w_addr   = core_win ? bus.core_addr  : bus.spi_addr;
    assign w_wdata  = core_win ? bus.core_wdata : bus.spi_wdata;
    assign w_wmask  = core_win ? bus.core_wmask : bus.spi_wmask;

    assign bus.spi_gnt  = spi_win;
    assign bus.core_gnt = core_win;
    assign bus.busy     = state != IDLE;

    // the rf_* registers double as the latched request; rf_we in ISSUE selects write vs read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            owner           <= 1'b0;
            bus.rf_addr     <= '0;
            bus.rf_we       <= 1'b0;
            bus.rf_wdata    <= '0;
            bus.rf_wmask    <= '0;
            bus.spi_rvalid  <= 1'b0;
            bus.core_rvalid <= 1'b0;
            bus.spi_rdata   <= '0;
            bus.core_rdata  <= '0;
        end else begin
            bus.rf_we       <= grant && w_we;
            bus.rf_wdata    <= grant && w_we ? w_wdata : '0;
            bus.rf_wmask    <= grant && w_we ? w_wmask : '0;
            bus.spi_rvalid  <= state == RDATA && !owner;
            bus.core_rvalid <= state == RDATA && owner;
            if (grant) bus.rf_addr <= w_addr;
            if (grant) owner <= core_win;
            if (state == RDATA && owner) bus.core_rdata <= bus.rf_rdata;
            if (state == RDATA && !owner) bus.spi_rdata <= bus.rf_rdata;
            if (core_win) wait_cnt <= '0;
            else if (idle && bus.core_req && wait_cnt != WMAX) wait_cnt <= wait_cnt + 4'd1;
            state <= grant ? ISSUE : state == ISSUE ? (bus.rf_we ? IDLE : RDATA) : IDLE;
        end
    end
endmodule

// File: tb/tb_rf_arbiter.sv
// tb_rf_arbiter: directed stimulus with per-output scoreboard queues checked by a negedge monitor.
module tb_rf_arbiter;
    typedef struct {
        int          cyc;
        logic [63:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_arbiter_if #(.AW(3), .DW(32), .MW(4)) bus ();
    rf_arbiter #(.AW(3), .DW(32), .MW(4), .MAX_WAIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t q_sg[$], q_cg[$], q_wr[$], q_sr[$], q_cr[$];
    int checks = 0, failures = 0, cyc = 0, t;
    logic [31:0] mem [8] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'h0, 32'h0, 32'h0, 32'h12345678, 32'h0, 32'h0};
    exp_t e;
    bit   have;

    always @(posedge clk) cyc <= cyc + 1;

    // regfile model: synchronous read, one-cycle latency, byte-masked writes
    always @(posedge clk) begin
        if (bus.rf_we)
            for (int b = 0; b < 4; b++)
                if (bus.rf_wmask[b]) mem[bus.rf_addr][8*b +: 8] <= bus.rf_wdata[8*b +: 8];
        bus.rf_rdata <= mem[bus.rf_addr];
    end

    function automatic logic [63:0] wv(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
        return {25'd0, a, d, m};
    endfunction

    function automatic void cmp(input string nm, input bit h, input exp_t x, input logic [63:0] v);
        checks++;
        if (!h) begin
            failures++;
            $display("FAIL %s: unexpected event at cycle %0d value %h", nm, cyc, v);
        end else if (x.cyc != cyc || x.val != v) begin
            failures++;
            $display("FAIL %s: got cycle %0d value %h, want cycle %0d value %h", nm, cyc, v, x.cyc, x.val);
        end
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endfunction

    always @(negedge clk) if (!rst) begin
        if (bus.spi_gnt) begin
            have = q_sg.size() > 0; e = '{0, 64'd0}; if (have) e = q_sg.pop_front();
            cmp("spi_gnt", have, e, 64'd0);
        end
        if (bus.core_gnt) begin
            have = q_cg.size() > 0; e = '{0, 64'd0}; if (have) e = q_cg.pop_front();
            cmp("core_gnt", have, e, 64'd0);
        end
        if (bus.rf_we) begin
            have = q_wr.size() > 0; e = '{0, 64'd0}; if (have) e = q_wr.pop_front();
            cmp("rf_write", have, e, wv(bus.rf_addr, bus.rf_wdata, bus.rf_wmask));
        end
        if (bus.spi_rvalid) begin
            have = q_sr.size() > 0; e = '{0, 64'd0}; if (have) e = q_sr.pop_front();
            cmp("spi_rvalid", have, e, {32'd0, bus.spi_rdata});
        end
        if (bus.core_rvalid) begin
            have = q_cr.size() > 0; e = '{0, 64'd0}; if (have) e = q_cr.pop_front();
            cmp("core_rvalid", have, e, {32'd0, bus.core_rdata});
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        {bus.spi_req, bus.spi_we, bus.spi_addr, bus.spi_wdata, bus.spi_wmask} = '0;
        {bus.core_req, bus.core_we, bus.core_addr, bus.core_wdata, bus.core_wmask} = '0;
        bus.spi_req = 1'b1;
        #2;
        chk("rst_spi_gnt", {63'd0, bus.spi_gnt}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_rf", wv(bus.rf_addr, bus.rf_wdata, bus.rf_wmask), 64'd0);
        chk("rst_rf_we", {63'd0, bus.rf_we}, 64'd0);
        bus.spi_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // SPI write addr 3
        nxt(); t = cyc;
        bus.spi_req = 1; bus.spi_we = 1; bus.spi_addr = 3; bus.spi_wdata = 32'hDEADBEEF; bus.spi_wmask = 4'hF;
        q_sg.push_back('{t, 64'd0});
        q_wr.push_back('{t + 1, wv(3'd3, 32'hDEADBEEF, 4'hF)});
        nxt(); bus.spi_req = 0;
        chk("wr_busy_c1", {63'd0, bus.busy}, 64'd1);
        nxt();
        chk("wr_busy_c2", {63'd0, bus.busy}, 64'd0);

        // core read addr 5
        nxt(); t = cyc;
        bus.core_req = 1; bus.core_we = 0; bus.core_addr = 5;
        q_cg.push_back('{t, 64'd0});
        q_cr.push_back('{t + 3, 64'h12345678});
        nxt(); bus.core_req = 0;
        chk("rd_issue_rf", wv(bus.rf_addr, bus.rf_wdata, bus.rf_wmask), wv(3'd5, 32'd0, 4'd0));
        chk("rd_issue_we", {63'd0, bus.rf_we}, 64'd0);
        repeat (3) nxt();

        // both requesters held: SPI x4 then core
        nxt(); t = cyc;
        bus.spi_req = 1; bus.spi_we = 1; bus.spi_addr = 4; bus.spi_wdata = 32'h5A5A0004; bus.spi_wmask = 4'hF;
        bus.core_req = 1; bus.core_we = 1; bus.core_addr = 6; bus.core_wdata = 32'hC0C00006; bus.core_wmask = 4'h3;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) begin
                q_cg.push_back('{t + 2*k, 64'd0});
                q_wr.push_back('{t + 2*k + 1, wv(3'd6, 32'hC0C00006, 4'h3)});
            end else begin
                q_sg.push_back('{t + 2*k, 64'd0});
                q_wr.push_back('{t + 2*k + 1, wv(3'd4, 32'h5A5A0004, 4'hF)});
            end
        end
        repeat (20) nxt();
        bus.spi_req = 0; bus.core_req = 0;
        repeat (2) nxt();

        // back-to-back SPI reads of addr 0 then 1
        nxt(); t = cyc;
        bus.spi_req = 1; bus.spi_we = 0; bus.spi_addr = 0;
        q_sg.push_back('{t, 64'd0});
        q_sg.push_back('{t + 3, 64'd0});
        q_sr.push_back('{t + 3, 64'hA0A0A0A0});
        q_sr.push_back('{t + 6, 64'hB1B1B1B1});
        nxt(); bus.spi_addr = 1;
        repeat (3) nxt();
        bus.spi_req = 0;
        repeat (3) nxt();

        // reset during RDATA of a core read
        nxt(); t = cyc;
        bus.core_req = 1; bus.core_we = 0; bus.core_addr = 5;
        q_cg.push_back('{t, 64'd0});
        nxt(); bus.core_req = 0;
        nxt();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("mid_rst_rf", wv(bus.rf_addr, bus.rf_wdata, bus.rf_wmask), 64'd0);
        chk("mid_rst_rf_we", {63'd0, bus.rf_we}, 64'd0);
        chk("mid_rst_rvalid", {62'd0, bus.spi_rvalid, bus.core_rvalid}, 64'd0);
        chk("mid_rst_rdata", {bus.spi_rdata, bus.core_rdata}, 64'd0);
        nxt(); rst = 1'b0;
        repeat (3) nxt();
        nxt(); t = cyc;
        bus.spi_req = 1; bus.spi_we = 0; bus.spi_addr = 3;
        q_sg.push_back('{t, 64'd0});
        q_sr.push_back('{t + 3, 64'hDEADBEEF});
        nxt(); bus.spi_req = 0;
        repeat (3) nxt();

        // zero-mask SPI writes still issue and count against the waiting core
        nxt(); t = cyc;
        bus.spi_req = 1; bus.spi_we = 1; bus.spi_addr = 2; bus.spi_wdata = 32'h22222222; bus.spi_wmask = 4'h0;
        bus.core_req = 1; bus.core_we = 1; bus.core_addr = 6; bus.core_wdata = 32'hC0C00006; bus.core_wmask = 4'h3;
        for (int k = 0; k < 4; k++) begin
            q_sg.push_back('{t + 2*k, 64'd0});
            q_wr.push_back('{t + 2*k + 1, wv(3'd2, 32'h22222222, 4'h0)});
        end
        q_cg.push_back('{t + 8, 64'd0});
        q_wr.push_back('{t + 9, wv(3'd6, 32'hC0C00006, 4'h3)});
        nxt();
        chk("mask0_we", {63'd0, bus.rf_we}, 64'd1);
        chk("mask0_wmask", {60'd0, bus.rf_wmask}, 64'd0);
        repeat (9) nxt();
        bus.spi_req = 0; bus.core_req = 0;
        repeat (4) nxt();

        chk("left_spi_gnt", 64'(q_sg.size()), 64'd0);
        chk("left_core_gnt", 64'(q_cg.size()), 64'd0);
        chk("left_rf_write", 64'(q_wr.size()), 64'd0);
        chk("left_spi_rvalid", 64'(q_sr.size()), 64'd0);
        chk("left_core_rvalid", 64'(q_cr.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rf_arbiter.md
Name: rf_arbiter

Overview:
- Shares the single-port configuration register file between two requesters: the Quad-SPI peripheral port (already synchronised into the core clock domain) and the on-chip core sequencer port.
- Grants one access at a time using fixed SPI priority with a core anti-starvation counter.
- Drives registered regfile controls and returns read data to the winning requester only.

Parameters:
- AW, 3: regfile word-address width (equals RF_AWIDTH).
- DW, 32: data width (equals RF_WIDTH).
- MW, 4: byte-mask width (equals RF_MASK; DW/8).
- MAX_WAIT, 4: number of IDLE cycles the core may lose arbitration before it is forced to win; legal range 1..15.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous active-high reset
- spi_req  input  1  SPI access request; held with fields stable until spi_gnt
- spi_we  input  1  1 = write, 0 = read
- spi_addr  input  AW  word address
- spi_wdata  input  DW  write data
- spi_wmask  input  MW  byte write mask
- spi_gnt  output  1  single-cycle grant; request fields are sampled this cycle
- spi_rvalid  output  1  single-cycle read-data valid
- spi_rdata  output  DW  read data, valid with spi_rvalid
- core_req, core_we, core_addr, core_wdata, core_wmask  input  1/1/AW/DW/MW  core port, same rules as SPI port
- core_gnt, core_rvalid  output  1  same rules as SPI port
- core_rdata  output  DW  same rules as SPI port
- rf_addr  output  AW  regfile address
- rf_we  output  1  regfile write strobe, one cycle
- rf_wdata  output  DW  regfile write data
- rf_wmask  output  MW  regfile byte mask
- rf_rdata  input  DW  regfile read data, valid one cycle after rf_addr is presented with rf_we = 0
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; wait_cnt 0; owner 0 (SPI).
- States: IDLE, ISSUE, RDATA.
- IDLE: arbitration is combinational from the req inputs in the same cycle; at most one gnt is high.
  - Core wins if wait_cnt == MAX_WAIT and core_req = 1.
  - Otherwise SPI wins if spi_req = 1.
  - Otherwise core wins if core_req = 1.
  - On a grant: latch the winner's we/addr/wdata/wmask and record the owner; next state ISSUE.
- ISSUE (one cycle): rf_addr, rf_we, rf_wdata and rf_wmask come from the latched values.
  - Write: rf_we = 1; next state IDLE.
  - Read: rf_we = 0, rf_wmask = 0, rf_wdata = 0; next state RDATA.
- RDATA (one cycle): capture rf_rdata into the owner's rdata register; next state IDLE.
  - The owner's rvalid pulses for one cycle, the first cycle back in IDLE.
  - The non-owner's rdata and rvalid are unchanged (rvalid stays 0).
- Outside ISSUE: rf_we = 0, rf_wmask = 0; rf_addr holds its last value.
- Timing: write occupies 2 cycles (grant to strobe latency 1); read occupies 3 cycles (grant to rvalid latency 3).
  - A new grant may occur in the same IDLE cycle that rvalid is high.
- wait_cnt (4 bits):
  - In IDLE, increments when core_req = 1 and core is not granted; saturates at MAX_WAIT.
  - Clears to 0 on a core grant.
  - Holds in ISSUE and RDATA.
- Simultaneous spi_req and core_req with wait_cnt < MAX_WAIT: SPI wins and wait_cnt increments.
- Requests are never dropped: a requester holds req until gnt. Dropping req before gnt is legal, and no access results.
- wmask = 0 on a write: the access is still issued with rf_we = 1 and rf_wmask = 0. It is granted and counted normally.
- Reset mid-operation (ISSUE or RDATA): return to IDLE immediately; the pending read is discarded and no rvalid follows; rf_we is forced to 0 asynchronously.
- No combinational path from rf_rdata to any output.

Test Plan:
- Reset, then SPI write addr 3, wdata 0xDEADBEEF, mask 0xF: spi_gnt in cycle 0; rf_we = 1, rf_addr = 3, rf_wmask = 0xF in cycle 1; busy low in cycle 2.
- Core read addr 5 with the regfile model returning 0x12345678: core_gnt at cycle 0; core_rvalid = 1 and core_rdata = 0x12345678 at cycle 3; spi_rvalid stays 0.
- spi_req and core_req held high continuously, MAX_WAIT = 4: grants run SPI, SPI, SPI, SPI, core, then repeat; wait_cnt returns to 0 after each core grant.
- Back-to-back SPI reads of addrs 0 and 1: second spi_gnt lands in the same cycle as the first spi_rvalid; two rvalid pulses are spaced exactly 3 cycles apart.
- Assert rst during RDATA of a core read: all outputs 0 asynchronously; no core_rvalid after release; the next request is granted normally.
- SPI write with wmask = 0x0 at addr 2: rf_we = 1 and rf_wmask = 0x0 for one cycle; the grant still increments core wait_cnt if core_req is high.
